// File: rtl/agnus_blitter_pkg.sv
// -----------------------------------------------------------------------------
// agnus_blitter_pkg
// Shared definitions for the blitter channel sequencer: register addresses,
// channel (pointer/modulo select) codes, counter widths, sequencer states and
// a helper that finds the next enabled DMA channel inside a word.
//
// Build option: ECS_BIGBLIT_EN widens the row/word counters to 15/11 bits and
// adds the BLTSIZV/BLTSIZH registers.
// -----------------------------------------------------------------------------
package agnus_blitter_pkg;

  // Register bus addresses (byte address; the bus carries bits [8:1]).
  localparam logic [8:0] BLTCON0 = 9'h040;
  localparam logic [8:0] BLTCON1 = 9'h042;
  localparam logic [8:0] BLTSIZE = 9'h058;
  localparam logic [8:0] BLTSIZV = 9'h05C;
  localparam logic [8:0] BLTSIZH = 9'h05E;

  // Channel codes driven on ptrsel/modsel.
  localparam logic [1:0] CHA = 2'b10;
  localparam logic [1:0] CHB = 2'b01;
  localparam logic [1:0] CHC = 2'b00;
  localparam logic [1:0] CHD = 2'b11;

`ifdef ECS_BIGBLIT_EN
  localparam int HCNT_W = 15;
  localparam int WCNT_W = 11;
`else
  localparam int HCNT_W = 10;
  localparam int WCNT_W = 6;
`endif

  // ST_SA..ST_SD are consecutive so a slot state doubles as the index of the
  // following channel (ST_SA=1 -> B is channel index 1).
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SA   = 3'd1,
    ST_SB   = 3'd2,
    ST_SC   = 3'd3,
    ST_SD   = 3'd4,
    ST_SN   = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  // First enabled channel at or after channel index 'start' (0=A .. 3=D).
  // use_mask bit 3 is A, bit 0 is D. Returns ST_IDLE when none is enabled.
  function automatic state_e first_slot_from(input logic [3:0] use_mask,
                                             input int         start);
    state_e res;
    logic   found;
    res   = ST_IDLE;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && i >= start && use_mask[3-i]) begin
        found = 1'b1;
        res   = state_e'(3'(i + 1));
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/agnus_blitter_sizecnt.sv
// -----------------------------------------------------------------------------
// agnus_blitter_sizecnt
// Word and row down-counters for an area blit. A raw value of 0 stands for the
// counter's maximum (2^W); plain modular decrement of 0 yields 2^W-1, so no
// special case is needed beyond never treating 0 as "last".
//
// Ports:
//   clk, reset      bus clock, asynchronous active-high reset
//   load            load height/width (single cycle, already clock-enabled)
//   height, width   blit size, 0 = maximum
//   step            one word finished (single cycle, already clock-enabled)
//   last_word       current word is the last of its row
//   last_row        current row is the last of the blit
// Counter widths follow ECS_BIGBLIT_EN through the package.
// -----------------------------------------------------------------------------
module agnus_blitter_sizecnt
  import agnus_blitter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HCNT_W-1:0] height,
  input  logic [WCNT_W-1:0] width,
  input  logic              step,
  output logic              last_word,
  output logic              last_row
);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WCNT_W-1:0] width_q, width_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hcnt_d  = hcnt_q;
    wcnt_d  = wcnt_q;
    width_d = width_q;
    if (load) begin
      hcnt_d  = height;
      wcnt_d  = width;
      width_d = width;
    end else if (step) begin
      if (last_word) begin
        wcnt_d = width_q;
        hcnt_d = hcnt_q - HCNT_W'(1);
      end else begin
        wcnt_d = wcnt_q - WCNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q  <= '0;
      wcnt_q  <= '0;
      width_q <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      wcnt_q  <= wcnt_d;
      width_q <= width_d;
    end
  end

  assign last_word = (wcnt_q == WCNT_W'(1));
  assign last_row  = (hcnt_q == HCNT_W'(1));

endmodule

// File: rtl/agnus_blitter_chanseq.sv
// -----------------------------------------------------------------------------
// agnus_blitter_chanseq
// Blitter channel sequencer for area-mode blits. Decodes BLTCON0/BLTCON1/
// BLTSIZE writes, walks the enabled channels A,B,C,D once per word, requests a
// chip bus slot for each and, on the granted cycle, strobes the pointer and
// modulo update controls toward the address generator.
//
// Ports:
//   clk, reset            bus clock, asynchronous active-high reset
//   clk7_en               clock enable; all state advances only when high
//   data_in               register bus data
//   reg_address_in[8:1]   register bus address
//   bus_ack               DMA slot granted (sampled with clk7_en)
//   bus_req, bus_we       slot request, slot is a write (channel D)
//   ptrsel, modsel        channel code A=10 B=01 C=00 D=11
//   enaptr,incptr,decptr  pointer update strobe / direction
//   addmod, submod        apply modulo at the end of a row
//   first_line_pixel      tied low (area mode only)
//   busy, done            blit in progress, end-of-blit pulse
// Build option: ECS_BIGBLIT_EN adds BLTSIZV/BLTSIZH and wider counters.
// -----------------------------------------------------------------------------
module agnus_blitter_chanseq
  import agnus_blitter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [15:0] data_in,
  input  logic [8:1]  reg_address_in,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [1:0]  ptrsel,
  output logic [1:0]  modsel,
  output logic        enaptr,
  output logic        incptr,
  output logic        decptr,
  output logic        addmod,
  output logic        submod,
  output logic        first_line_pixel,
  output logic        busy,
  output logic        done
);

  state_e            state_q, state_d;
  logic [3:0]        use_mask_q, use_mask_d;
  logic              desc_q, desc_d;
`ifdef ECS_BIGBLIT_EN
  logic [HCNT_W-1:0] vsize_q, vsize_d;
`endif

  logic              start;
  logic              step;
  logic [HCNT_W-1:0] load_h;
  logic [WCNT_W-1:0] load_w;
  logic              last_word, last_row;
  logic              grant;
  state_e            first_slot, next_in_word, word_state;

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done  = (state_q == ST_FIN);
  assign grant = clk7_en & bus_ack;

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  always_comb begin
    use_mask_d = use_mask_q;
    desc_d     = desc_q;
`ifdef ECS_BIGBLIT_EN
    vsize_d    = vsize_q;
`endif
    start      = 1'b0;
    load_h     = '0;
    load_w     = '0;

    // Control registers are frozen for the duration of a blit.
    if (clk7_en && !busy) begin
      if (reg_address_in == BLTCON0[8:1]) use_mask_d = data_in[11:8];
      if (reg_address_in == BLTCON1[8:1]) desc_d     = data_in[1];
`ifdef ECS_BIGBLIT_EN
      if (reg_address_in == BLTSIZV[8:1]) vsize_d    = data_in[14:0];
`endif
    end

    if (clk7_en && state_q == ST_IDLE) begin
      if (reg_address_in == BLTSIZE[8:1]) begin
        start = 1'b1;
`ifdef ECS_BIGBLIT_EN
        // OCS fields keep their own zero-means-max meaning in the wide counters.
        load_h = (data_in[15:6] == 10'd0) ? HCNT_W'(1024) : HCNT_W'(data_in[15:6]);
        load_w = (data_in[5:0] == 6'd0)   ? WCNT_W'(64)   : WCNT_W'(data_in[5:0]);
`else
        load_h = data_in[15:6];
        load_w = data_in[5:0];
`endif
      end
`ifdef ECS_BIGBLIT_EN
      if (reg_address_in == BLTSIZH[8:1]) begin
        start  = 1'b1;
        load_h = vsize_q;
        load_w = data_in[10:0];
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      use_mask_q <= '0;
      desc_q     <= 1'b0;
`ifdef ECS_BIGBLIT_EN
      vsize_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      use_mask_q <= use_mask_d;
      desc_q     <= desc_d;
`ifdef ECS_BIGBLIT_EN
      vsize_q    <= vsize_d;
`endif
    end
  end

  always_comb begin
    first_slot = first_slot_from(use_mask_q, 0);
    if (first_slot == ST_IDLE) first_slot = ST_SN;
    // A slot state's encoding equals the index of the channel after it.
    next_in_word = first_slot_from(use_mask_q, int'(state_q));
    word_state   = (last_word && last_row) ? ST_FIN : first_slot;
  end

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = first_slot;
      ST_SA, ST_SB, ST_SC, ST_SD: begin
        if (grant) begin
          if (next_in_word != ST_IDLE) begin
            state_d = next_in_word;
          end else begin
            step    = 1'b1;
            state_d = word_state;
          end
        end
      end
      ST_SN: begin
        if (clk7_en) begin
          step    = 1'b1;
          state_d = word_state;
        end
      end
      ST_FIN:  if (clk7_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req = 1'b0;
    bus_we  = 1'b0;
    ptrsel  = CHC;
    unique case (state_q)
      ST_SA:   begin bus_req = 1'b1; ptrsel = CHA; end
      ST_SB:   begin bus_req = 1'b1; ptrsel = CHB; end
      ST_SC:   begin bus_req = 1'b1; ptrsel = CHC; end
      ST_SD:   begin bus_req = 1'b1; ptrsel = CHD; bus_we = 1'b1; end
      default: ;
    endcase

    enaptr = 1'b0;
    incptr = 1'b0;
    decptr = 1'b0;
    addmod = 1'b0;
    submod = 1'b0;
    if (bus_req && grant) begin
      enaptr = 1'b1;
      incptr = !desc_q;
      decptr = desc_q;
      addmod = last_word && !desc_q;
      submod = last_word && desc_q;
    end
  end

  assign modsel           = ptrsel;
  assign first_line_pixel = 1'b0;

  agnus_blitter_sizecnt u_sizecnt (
    .clk       (clk),
    .reset     (reset),
    .load      (start),
    .height    (load_h),
    .width     (load_w),
    .step      (step),
    .last_word (last_word),
    .last_row  (last_row)
  );

endmodule

// File: tb/tb_agnus_blitter_chanseq.sv
// -----------------------------------------------------------------------------
// Testbench for agnus_blitter_chanseq. Each blit's expected slot sequence is
// generated from the row/word/channel rules and queued; a monitor pops and
// compares on every granted slot and checks the done pulse.
// -----------------------------------------------------------------------------
module tb_agnus_blitter_chanseq;
  import agnus_blitter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic [15:0] data_in;
  logic [8:1]  reg_address_in;
  logic        bus_ack;
  logic        bus_req, bus_we, enaptr, incptr, decptr, addmod, submod;
  logic        first_line_pixel, busy, done;
  logic [1:0]  ptrsel, modsel;

  agnus_blitter_chanseq dut (
    .clk              (clk),
    .reset            (reset),
    .clk7_en          (clk7_en),
    .data_in          (data_in),
    .reg_address_in   (reg_address_in),
    .bus_ack          (bus_ack),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .ptrsel           (ptrsel),
    .modsel           (modsel),
    .enaptr           (enaptr),
    .incptr           (incptr),
    .decptr           (decptr),
    .addmod           (addmod),
    .submod           (submod),
    .first_line_pixel (first_line_pixel),
    .busy             (busy),
    .done             (done)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ptrsel;
    logic       we;
    logic       inc;
    logic       dec;
    logic       am;
    logic       sm;
  } slot_t;

  slot_t sb[$];
  int    checks = 0, failures = 0;
  bit    active = 0;
  int    busy_cyc, wait_cyc, exp_units;
  int    done_seen = 0;
  bit    en_always = 0, ack_always = 0;
  int    hold_cnt = 0;

  localparam logic [7:0] NOP_ADDR = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Clock enable / grant driver.
  initial begin
    clk7_en = 1'b0;
    bus_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      clk7_en = en_always || ($urandom_range(0, 2) != 0);
      if (hold_cnt > 0) begin
        bus_ack = 1'b0;
        if (clk7_en) hold_cnt--;
      end else begin
        bus_ack = ack_always || ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    slot_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!(clk7_en && bus_ack && bus_req))
          check("strobe_idle", {enaptr, incptr, decptr, addmod, submod}, 5'b0);
        if (clk7_en) begin
          if (busy) busy_cyc++;
          if (bus_req && !bus_ack) begin
            wait_cyc++;
            if (sb.size() > 0) check("req_hold_ptrsel", ptrsel, sb[0].ptrsel);
            else               check("unexpected_req", bus_req, 1'b0);
          end
          if (bus_req && bus_ack) begin
            if (sb.size() == 0) begin
              check("unexpected_slot", bus_req, 1'b0);
            end else begin
              e = sb.pop_front();
              check("slot",
                    {ptrsel, bus_we, enaptr, incptr, decptr, addmod, submod, busy, modsel},
                    {e.ptrsel, e.we, 1'b1, e.inc, e.dec, e.am, e.sm, 1'b1, e.ptrsel});
            end
          end
          if (done) begin
            check("done_expected", done, active);
            if (active) begin
              check("done_slots_left", sb.size(), 0);
              check("done_busy", busy, 1'b0);
              check("no_bubble", busy_cyc - wait_cyc, exp_units);
              active = 0;
              done_seen++;
            end
          end
        end
      end
    end
  end

  task automatic write_reg(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    reg_address_in = a[8:1];
    data_in        = d;
    while (!clk7_en) @(negedge clk);
    @(posedge clk);
    #2;
    reg_address_in = NOP_ADDR;
  endtask

  // Expected slots follow directly from the blit description: rows x words,
  // each word visiting the enabled channels in A,B,C,D order.
  task automatic start_blit(input logic [3:0] use_m, input logic desc, input int h,
                            input int w, input logic [8:0] size_addr,
                            input logic [15:0] size_data, input int hold);
    logic [1:0] codes [4];
    slot_t      s;
    codes = '{CHA, CHB, CHC, CHD};
    write_reg(BLTCON0, {4'b0, use_m, 8'b0});
    write_reg(BLTCON1, {14'b0, desc, 1'b0});
    exp_units = 0;
    for (int r = 0; r < h; r++) begin
      for (int wi = 0; wi < w; wi++) begin
        if (use_m == 4'b0) exp_units++;
        for (int c = 0; c < 4; c++) begin
          if (use_m[3-c]) begin
            s.ptrsel = codes[c];
            s.we     = (c == 3);
            s.inc    = !desc;
            s.dec    = desc;
            s.am     = (wi == w - 1) && !desc;
            s.sm     = (wi == w - 1) && desc;
            sb.push_back(s);
            exp_units++;
          end
        end
      end
    end
    busy_cyc = 0;
    wait_cyc = 0;
    active   = 1;
    hold_cnt = hold;
    write_reg(size_addr, size_data);
  endtask

  task automatic wait_done(input int budget);
    int start_cnt, n;
    start_cnt = done_seen;
    n = 0;
    while (done_seen == start_cnt && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", done_seen - start_cnt, 1);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    logic [3:0] ru;
    logic       rd;
    int         rh, rw;

    reset          = 1'b1;
    data_in        = '0;
    reg_address_in = NOP_ADDR;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus_req, bus_we, ptrsel, modsel, enaptr, incptr, decptr, addmod, submod,
           first_line_pixel, busy, done}, '0);
    @(posedge clk);
    #3 reset = 1'b0;

    // Fixed directed cases with continuous enable and grant.
    en_always  = 1;
    ack_always = 1;
    start_blit(4'b1001, 1'b0, 2, 2, BLTSIZE, 16'h0082, 0);
    wait_done(1000);
    start_blit(4'b0100, 1'b1, 1, 1, BLTSIZE, 16'h0041, 0);
    wait_done(1000);
    start_blit(4'b1111, 1'b0, 1, 1, BLTSIZE, 16'h0041, 6);
    wait_done(1000);

    // Randomized blits with random enable and grant.
    en_always  = 0;
    ack_always = 0;
    for (int t = 0; t < 8; t++) begin
      ru = 4'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      rh = $urandom_range(1, 3);
      rw = $urandom_range(1, 5);
      start_blit(ru, rd, rh, rw, BLTSIZE, 16'((rh << 6) | rw), 0);
      wait_done(3000);
    end

    // Register rewrites during a blit must not disturb it.
    start_blit(4'b1100, 1'b0, 6, 4, BLTSIZE, 16'((6 << 6) | 4), 0);
    repeat (6) @(posedge clk);
    write_reg(BLTSIZE, 16'h0041);
    write_reg(BLTCON0, 16'h0100);
    write_reg(BLTCON1, 16'h0002);
    check("midblit_busy", busy, 1'b1);
    wait_done(3000);

    // Asynchronous reset mid-blit: busy drops at once, no done pulse.
    start_blit(4'b1111, 1'b0, 4, 10, BLTSIZE, 16'((4 << 6) | 10), 0);
    repeat (15) @(posedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_req", bus_req, 1'b0);
    active = 0;
    sb.delete();
    repeat (4) begin
      @(negedge clk);
      check("reset_no_done", done, 1'b0);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (20) @(posedge clk);
    check("post_reset_idle", {busy, bus_req, done}, 3'b0);

    // Empty mask with maximum size: 65536 no-request cycles.
    en_always  = 1;
    ack_always = 1;
    start_blit(4'b0000, 1'b0, 1024, 64, BLTSIZE, 16'h0000, 0);
    wait_done(70000);

`ifdef ECS_BIGBLIT_EN
    write_reg(BLTSIZV, 16'd3);
    start_blit(4'b0001, 1'b0, 3, 2048, BLTSIZH, 16'h0800, 0);
    wait_done(10000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agnus_blitter_chanseq.md
Name: agnus_blitter_chanseq

Overview:
- Blitter channel sequencer for area-mode blits; the command-issuing side of the blitter address generator.
- Decodes BLTCON0/BLTCON1/BLTSIZE register writes, counts words and rows, and requests chip bus slots for channels A, B, C and D.
- On each granted slot it drives the pointer-select/increment/modulo controls toward the address generator. Sits in Agnus between the register bus, the DMA arbiter and the address generator.

Parameters:
- BLTCON0 = 9'h040: register address of BLTCON0 (USEA..USED in bits 11:8).
- BLTCON1 = 9'h042: register address of BLTCON1 (DESC in bit 1).
- BLTSIZE = 9'h058: register address of BLTSIZE; a write starts the blit.

Ports:
- clk  in  1  bus clock.
- reset  in  1  asynchronous, active-high reset.
- clk7_en  in  1  clock enable; all state advances only when high.
- data_in  in  16  register bus data.
- reg_address_in  in  8 [8:1]  register bus address.
- bus_ack  in  1  DMA slot granted for the current bus_req, sampled with clk7_en.
- bus_req  out  1  blitter DMA slot request.
- bus_we  out  1  current slot is a write (channel D).
- ptrsel  out  2  channel code: A=10, B=01, C=00, D=11.
- modsel  out  2  always equal to ptrsel.
- enaptr  out  1  pointer update strobe.
- incptr  out  1  increment selected pointer.
- decptr  out  1  decrement selected pointer.
- addmod  out  1  add selected modulo.
- submod  out  1  subtract selected modulo.
- first_line_pixel  out  1  tied low (area mode only).
- busy  out  1  blit in progress (BBUSY).
- done  out  1  one clk7_en-qualified cycle pulse at blit end (feeds INTREQ BLIT).

Behaviour:
- Reset: state IDLE, all outputs 0, counters 0, latched use mask 0, desc 0.
- BLTCON0 write: latch use[3:0]=data_in[11:8]. BLTCON1 write: latch desc=data_in[1]. Both are ignored while busy.
- BLTSIZE write in IDLE: height = data_in[15:6] (0 means 1024), width = data_in[5:0] (0 means 64). Load hcnt/wcnt, set busy on the next clk7_en edge, enter the first slot.
- BLTSIZE write while busy: ignored.
- State machine: IDLE, SA, SB, SC, SD, SN, FIN.
  - Per word, visit SA, SB, SC, SD in order, skipping channels whose use bit is 0.
  - If the use mask is 0000, visit SN: one clk7_en cycle, no request.
- In SA/SB/SC/SD:
  - bus_req=1 and ptrsel=channel code, held stable until bus_ack.
  - On a cycle with clk7_en & bus_ack: enaptr=1 combinationally that same cycle, incptr=!desc, decptr=desc.
  - If wcnt==1 (last word of row): also addmod=!desc, submod=desc.
  - The state advances at the end of that cycle.
- bus_we=1 only in SD.
- After the last enabled slot of a word:
  - wcnt>1: decrement wcnt, return to the first enabled slot.
  - wcnt==1 and hcnt>1: reload wcnt with width, decrement hcnt, continue.
  - wcnt==1 and hcnt==1: go to FIN.
- FIN: busy=0, done=1 for one clk7_en cycle, then IDLE.
- Control strobes (enaptr, incptr, decptr, addmod, submod) are 0 in every cycle without clk7_en & bus_ack.
- Latency: slot n+1 requested on the first clk7_en cycle after the slot n grant; no bubble cycles.
- Asynchronous reset mid-blit: immediate return to IDLE with busy=0 and no done pulse.

Optional Feature:
- Macro: ECS_BIGBLIT_EN.
- Defined:
  - BLTSIZV (9'h05C) latches height[14:0]; 0 means 32768.
  - BLTSIZH (9'h05E) latches width[10:0]; 0 means 2048.
  - A BLTSIZH write starts the blit.
  - Counters widen to 15/11 bits.
  - A BLTSIZE write still works with OCS field widths.
- Undefined: BLTSIZV/BLTSIZH writes are ignored; counters are 10/6 bits.

Decomposition:
- Shared package agnus_blitter_pkg:
  - channel codes CHA/CHB/CHC/CHD;
  - register addresses BLTCON0, BLTCON1, BLTSIZE, BLTSIZV, BLTSIZH;
  - state enumeration.
- One natural sub-module, agnus_blitter_sizecnt: the word/row down-counters with load, zero-means-max, and last-word/last-row flags.

Test Plan:
- use=1001, desc=0, BLTSIZE=16'h0082 (h=2,w=2), bus_ack always 1:
  - slot order A,D,A,D,A,D,A,D;
  - addmod=1 on slots 3,4,7,8;
  - done pulse after slot 8; busy=0.
- desc=1, use=0100, BLTSIZE=16'h0041 (1x1): single B slot with decptr=1, submod=1, ptrsel=01; done follows.
- use=1111, BLTSIZE=16'h0041, bus_ack held low 5 cycles: bus_req stays 1 with ptrsel=10 and enaptr=0 until the grant, then B, C, D.
- use=0000, BLTSIZE=16'h0000: 65536 SN cycles, no bus_req ever; done pulse at the end.
- BLTSIZE rewritten mid-blit and BLTCON0 changed mid-blit: no effect on counts or channels; async reset asserted mid-blit drops busy immediately, with no done pulse.
- ECS_BIGBLIT_EN defined: BLTSIZV=3, BLTSIZH=2048, use=0001 → 6144 D slots, then done.
